// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline and its downstream packer:
// image size defaults, edge encoding and packed FIFO entry layout.
package canny_pkg;

  localparam logic [7:0] EDGE_ON = 8'hFF;

  localparam int IMG_W_DEFAULT = 256;
  localparam int IMG_H_DEFAULT = 256;

  // Packed FIFO entry: {sof, eol, eof, data[7:0]}
  localparam int ENTRY_W = 11;
  localparam int SOF_BIT = 10;
  localparam int EOL_BIT = 9;
  localparam int EOF_BIT = 8;

  function automatic logic edge_bit(input logic [7:0] pixel);
    return |(pixel & EDGE_ON);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head stage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] head_r;
  logic             valid_r;

  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] head_n;

  // Next-state for pointers, occupancy and the presented head entry
  always_comb begin
    pop_s    = pop & valid_r;
    full_s   = (count_r == CW'(DEPTH));
    push_s   = push & (~full_s | pop_s);
    rd_ptr_n = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    count_n  = count_r + CW'(push_s) - CW'(pop_s);
    // Entry written this cycle becomes the head when nothing older remains
    if (push_s && ((count_r - CW'(pop_s)) == '0)) begin
      head_n = push_data;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end
  end

  // Storage, pointers and registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_n;
      count_r  <= count_n;
      head_r   <= head_n;
      valid_r  <= (count_n != '0);
    end
  end

  assign pop_data = head_r;
  assign valid    = valid_r;
  assign full     = full_s;
  assign empty    = (count_r == '0);
  assign count    = count_r;

endmodule

// File: rtl/edge_frame_packer.sv
// Packs the binary Canny edge stream into bytes with frame/line markers,
// buffers them against downstream stalls and reports per-frame edge counts.
module edge_frame_packer
  import canny_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEFAULT,
  parameter int IMG_H      = IMG_H_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       pixel_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic [CNT_W-1:0] edge_count,
  output logic             frame_done,
  output logic             overflow
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  logic [6:0]         shift_r;
  logic [CNT_W-1:0]   acc_r;
  logic [CNT_W-1:0]   edge_count_r;
  logic               frame_done_r;
  logic               overflow_r;

  logic               bit_s;
  logic [7:0]         byte_s;
  logic               col_last_s;
  logic               row_last_s;
  logic               frame_last_s;
  logic               push_s;
  logic               pop_fire_s;
  logic               drop_s;
  logic [CNT_W-1:0]   acc_inc_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [FCNT_W-1:0]  fifo_count_s;
  logic               fifo_unused_s;

  // Byte assembly, raster position decode and drop detection
  always_comb begin
    bit_s        = edge_bit(pixel_in);
    byte_s       = {shift_r, bit_s};
    col_last_s   = (col_r == COL_W'(IMG_W - 1));
    row_last_s   = (row_r == ROW_W'(IMG_H - 1));
    frame_last_s = col_last_s & row_last_s;
    push_s       = in_valid & (col_r[2:0] == 3'd7);
    pop_fire_s   = m_valid & m_ready;
    drop_s       = push_s & fifo_full_s & ~pop_fire_s;
    acc_inc_s    = acc_r + CNT_W'(bit_s);
    entry_s          = '0;
    entry_s[7:0]     = byte_s;
    entry_s[SOF_BIT] = (row_r == '0) && (col_r == COL_W'(7));
    entry_s[EOL_BIT] = col_last_s;
    entry_s[EOF_BIT] = frame_last_s;
  end

  // Raster counters, shift register and running edge accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r   <= '0;
      row_r   <= '0;
      shift_r <= '0;
      acc_r   <= '0;
    end else if (in_valid) begin
      shift_r <= byte_s[6:0];
      if (col_last_s) begin
        col_r <= '0;
        row_r <= row_last_s ? '0 : (row_r + ROW_W'(1));
      end else begin
        col_r <= col_r + COL_W'(1);
      end
      acc_r <= frame_last_s ? '0 : acc_inc_s;
    end
  end

  // Frame statistics and sticky loss flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_count_r <= '0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      frame_done_r <= in_valid & frame_last_s;
      if (in_valid && frame_last_s) begin
        edge_count_r <= acc_inc_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (m_ready),
    .pop_data  (head_s),
    .valid     (m_valid),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign fifo_unused_s = fifo_empty_s ^ (^fifo_count_s);

  assign m_data     = head_s[7:0];
  assign m_sof      = head_s[SOF_BIT];
  assign m_eol      = head_s[EOL_BIT];
  assign m_eof      = head_s[EOF_BIT];
  assign edge_count = edge_count_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_edge_frame_packer.sv
// Randomized bench for edge_frame_packer against a raster/queue reference model,
// plus directed frames with fixed expected bytes and counts.
module tb_edge_frame_packer;

  localparam int W = 16;
  localparam int H = 2;
  localparam int D = 2;
  localparam int CNT_W = $clog2(W * H + 1);
  localparam int PAT_81 = 0, PAT_ZERO = 1, PAT_ONES = 2, PAT_RAND = 3;
  localparam int RDY_LOW = 0, RDY_HIGH = 1, RDY_RAND = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic m_ready = 1'b0;
  logic m_valid, m_sof, m_eol, m_eof, frame_done, overflow;
  logic [7:0] m_data;
  logic [CNT_W-1:0] edge_count;

  always #5 clk = ~clk;

  edge_frame_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_in(pixel_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .edge_count(edge_count), .frame_done(frame_done), .overflow(overflow)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // Reference model state: raster position, byte builder, expected FIFO contents
  int mcol, mrow, macc, exp_ec, fd_seen, ones;
  bit exp_fd, exp_ovf;
  logic [7:0] mshift;
  logic [10:0] q[$];
  logic [10:0] got_q[$];

  task automatic model_reset();
    mcol = 0; mrow = 0; macc = 0; exp_ec = 0;
    exp_fd = 1'b0; exp_ovf = 1'b0; mshift = 8'd0;
    q.delete();
  endtask

  task automatic model_update(input logic v, input logic [7:0] p, input logic r);
    bit pop, b;
    int occ;
    logic [10:0] entry;
    pop = r && (q.size() > 0);
    occ = q.size();
    exp_fd = 1'b0;
    if (pop) void'(q.pop_front());
    if (v) begin
      b = (p != 8'd0);
      mshift = {mshift[6:0], b};
      if (b) macc++;
      if (mcol % 8 == 7) begin
        entry = {(mrow == 0 && mcol == 7), (mcol == W - 1), (mcol == W - 1 && mrow == H - 1), mshift};
        if (occ < D || pop) q.push_back(entry);
        else exp_ovf = 1'b1;
      end
      if (mcol == W - 1 && mrow == H - 1) begin
        exp_ec = macc;
        macc = 0;
        exp_fd = 1'b1;
      end
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; m_ready = 1'b0; pixel_in = 8'd0;
    #2;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", {m_sof, m_eol, m_eof, m_data}, 11'd0);
    check("rst_edge_count", edge_count, 0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  // One clock: check pre-edge stream outputs, advance model, check registered status
  task automatic step(input logic v, input logic [7:0] p, input logic r);
    in_valid = v; pixel_in = p; m_ready = r;
    #1;
    check("m_valid", m_valid, (q.size() != 0));
    if (r && q.size() > 0) begin
      check("byte", {m_sof, m_eol, m_eof, m_data}, q[0]);
      got_q.push_back({m_sof, m_eol, m_eof, m_data});
    end
    @(posedge clk);
    model_update(v, p, r);
    @(negedge clk);
    check("frame_done", frame_done, exp_fd);
    check("edge_count", edge_count, exp_ec);
    check("overflow", overflow, exp_ovf);
    if (frame_done) fd_seen++;
  endtask

  function automatic logic [7:0] rand_pixel();
    return ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
  endfunction

  task automatic run_pixels(input int n, input int pat, input int rdy, input bit bubbles);
    int k;
    logic v, r;
    logic [7:0] p;
    k = 0;
    while (k < n) begin
      v = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (pat)
        PAT_81:   p = (k % 8 == 0 || k % 8 == 7) ? 8'd255 : 8'd0;
        PAT_ZERO: p = 8'd0;
        PAT_ONES: p = 8'd255;
        default:  p = rand_pixel();
      endcase
      case (rdy)
        RDY_LOW:  r = 1'b0;
        RDY_HIGH: r = 1'b1;
        default:  r = ($urandom_range(0, 1) == 1);
      endcase
      if (v && p != 8'd0) ones++;
      step(v, p, r);
      if (v) k++;
    end
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while (q.size() > 0 && c < max_cycles) begin
      step(1'b0, 8'd0, 1'b1);
      c++;
    end
    check("drain_empty", m_valid, 1'b0);
  endtask

  initial begin
    logic [10:0] exp81[4];
    exp81[0] = 11'h481; exp81[1] = 11'h281; exp81[2] = 11'h081; exp81[3] = 11'h381;
    @(negedge clk);
    do_reset();

    // Directed 255,0,...,0,255 frame with free-flowing output
    got_q.delete(); fd_seen = 0;
    run_pixels(W * H, PAT_81, RDY_HIGH, 1'b0);
    drain(8);
    check("p81_nbytes", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("p81_entry", got_q[i], exp81[i]);
    check("p81_edge_count", edge_count, 8);
    check("p81_fd_pulses", fd_seen, 1);

    // All-zero frame then all-255 frame
    got_q.delete();
    run_pixels(W * H, PAT_ZERO, RDY_HIGH, 1'b0);
    drain(8);
    check("zero_edge_count", edge_count, 0);
    for (int i = 0; i < got_q.size(); i++) check("zero_data", got_q[i][7:0], 8'h00);
    got_q.delete();
    run_pixels(W * H, PAT_ONES, RDY_HIGH, 1'b0);
    drain(8);
    check("ones_nbytes", got_q.size(), 4);
    check("ones_edge_count", edge_count, 32);
    for (int i = 0; i < got_q.size(); i++) check("ones_data", got_q[i][7:0], 8'hFF);

    // Stalled downstream for a whole frame: two bytes kept, loss flagged
    do_reset();
    got_q.delete();
    run_pixels(W * H, PAT_RAND, RDY_LOW, 1'b0);
    check("stall_overflow", overflow, 1'b1);
    drain(10);
    check("stall_nbytes", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("stall_b0_flags", got_q[0][10:8], 3'b100);
      check("stall_b1_flags", got_q[1][10:8], 3'b010);
    end

    // FIFO full but popped in the same cycle as the completing pixel
    do_reset();
    got_q.delete();
    run_pixels(16, PAT_RAND, RDY_LOW, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, rand_pixel(), 1'b0);
    step(1'b1, rand_pixel(), 1'b1);
    check("fullpop_overflow", overflow, 1'b0);
    run_pixels(8, PAT_RAND, RDY_HIGH, 1'b0);
    drain(8);
    check("fullpop_nbytes", got_q.size(), 4);
    check("fullpop_overflow_end", overflow, 1'b0);

    // Reset mid-line, then a clean frame
    do_reset();
    run_pixels(5, PAT_ONES, RDY_HIGH, 1'b0);
    do_reset();
    got_q.delete(); ones = 0; fd_seen = 0;
    run_pixels(W * H, PAT_RAND, RDY_HIGH, 1'b0);
    drain(8);
    check("rstmid_nbytes", got_q.size(), 4);
    if (got_q.size() > 0) check("rstmid_first_sof", got_q[0][10], 1'b1);
    check("rstmid_edge_count", edge_count, ones);
    check("rstmid_fd_pulses", fd_seen, 1);

    // Random bubbles and random backpressure over several frames
    do_reset();
    fd_seen = 0;
    for (int f = 0; f < 4; f++) begin
      ones = 0;
      run_pixels(W * H, PAT_RAND, RDY_RAND, 1'b1);
      check("rand_edge_count", edge_count, ones);
    end
    drain(20);
    check("rand_fd_pulses", fd_seen, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
